// File: rtl/tt_ctrl_pkg.sv
// Shared types and defaults for the tt_ctrl_select project-select controller.
package tt_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_PRE,
        ST_UPD,
        ST_POST,
        ST_ON
    } ctrl_state_t;

    typedef enum logic [1:0] {
        PEND_NONE,
        PEND_INC,
        PEND_RST
    } pend_t;

    localparam int GUARD_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/tt_pad_sync.sv
// N-stage synchroniser for one asynchronous pad input; clears to 0 on rst.
module tt_pad_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/tt_ctrl_select.sv
// Project-select controller: synchronised pads drive mux address/enable with break-before-make.
// Optional macro TT_CTRL_SKIP_EMPTY_EN: increments skip slots not populated in PROJ_MASK.
module tt_ctrl_select
    import tt_ctrl_pkg::*;
#(
    parameter int ADDR_W       = 5,
    parameter int NUM_PROJ     = 32,
    parameter int SYNC_STAGES  = 2,
    parameter int GUARD_CYCLES = GUARD_CYCLES_DEFAULT
`ifdef TT_CTRL_SKIP_EMPTY_EN
    ,
    parameter logic [NUM_PROJ-1:0] PROJ_MASK = '1
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ctrl_sel_rst_n,
    input  logic              ctrl_sel_inc,
    input  logic              ctrl_ena,
    output logic [ADDR_W-1:0] addr,
    output logic              ena,
    output logic              busy,
    output logic              wrap
);

    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_PROJ - 1);
    localparam logic [7:0]        GUARD = 8'(GUARD_CYCLES);
`ifdef TT_CTRL_SKIP_EMPTY_EN
    localparam logic [2**ADDR_W-1:0] MASK_EXT = (2**ADDR_W)'(PROJ_MASK);
`endif

    logic [2:0]        w_pad;
    logic [2:0]        w_pad_s;
    logic              w_sel_rst_n_s;
    logic              w_inc_s;
    logic              w_ena_s;
    logic              w_inc_rise;

    logic              r_inc_d;
    ctrl_state_t       r_state;
    ctrl_state_t       w_state_next;
    pend_t             r_pend;
    pend_t             w_pend_next;
    logic [7:0]        r_cnt;
    logic [7:0]        w_cnt_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_next;
    logic              r_ena;
    logic              r_busy;
    logic              w_upd_done;
    logic              w_wrap;

    assign w_pad = {ctrl_ena, ctrl_sel_inc, ctrl_sel_rst_n};

    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        tt_pad_sync #(
            .STAGES(SYNC_STAGES)
        ) u_sync (
            .clk (clk),
            .rst (rst),
            .i_d (w_pad[gi]),
            .o_q (w_pad_s[gi])
        );
    end

    assign w_sel_rst_n_s = w_pad_s[0];
    assign w_inc_s       = w_pad_s[1];
    assign w_ena_s       = w_pad_s[2];
    assign w_inc_rise    = w_inc_s & ~r_inc_d;

    // Address step for the UPD state; with skip-empty, UPD repeats until a populated slot is reached.
    always_comb begin
        w_addr_next = r_addr;
        w_upd_done  = 1'b1;
        w_wrap      = 1'b0;
        if (r_state == ST_UPD) begin
            if (r_pend == PEND_RST) begin
                w_addr_next = '0;
            end else if (r_pend == PEND_INC) begin
`ifdef TT_CTRL_SKIP_EMPTY_EN
                if (MASK_EXT == '0) begin
                    w_addr_next = '0;
                end else begin
                    w_addr_next = (r_addr == LAST) ? '0 : r_addr + ADDR_W'(1);
                    w_wrap      = (r_addr == LAST);
                    w_upd_done  = MASK_EXT[w_addr_next];
                end
`else
                w_addr_next = (r_addr == LAST) ? '0 : r_addr + ADDR_W'(1);
                w_wrap      = (r_addr == LAST);
`endif
            end
        end
    end

    // Pending event: a held select-reset wins; an increment only lands in an empty slot.
    always_comb begin
        w_pend_next = r_pend;
        if (r_state == ST_UPD && w_upd_done) begin
            w_pend_next = PEND_NONE;
        end
        if (!w_sel_rst_n_s) begin
            w_pend_next = PEND_RST;
        end else if (w_inc_rise && w_pend_next == PEND_NONE) begin
            w_pend_next = PEND_INC;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            ST_OFF: begin
                if (r_pend != PEND_NONE) begin
                    w_state_next = ST_UPD;
                end else if (w_ena_s) begin
                    w_state_next = ST_POST;
                    w_cnt_next   = GUARD;
                end
            end
            ST_ON: begin
                if (r_pend != PEND_NONE) begin
                    w_state_next = ST_PRE;
                    w_cnt_next   = GUARD;
                end else if (!w_ena_s) begin
                    w_state_next = ST_OFF;
                end
            end
            ST_PRE: begin
                if (r_cnt <= 8'd1) begin
                    w_state_next = ST_UPD;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt - 8'd1;
                end
            end
            ST_UPD: begin
                if (w_upd_done) begin
                    if (w_ena_s) begin
                        w_state_next = ST_POST;
                        w_cnt_next   = GUARD;
                    end else begin
                        w_state_next = ST_OFF;
                    end
                end
            end
            ST_POST: begin
                if (r_pend != PEND_NONE) begin
                    w_state_next = ST_PRE;
                    w_cnt_next   = GUARD;
                end else if (r_cnt <= 8'd1) begin
                    w_state_next = w_ena_s ? ST_ON : ST_OFF;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt - 8'd1;
                end
            end
            default: begin
                w_state_next = ST_OFF;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_OFF;
            r_pend  <= PEND_NONE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_inc_d <= 1'b0;
            r_ena   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pend  <= w_pend_next;
            r_cnt   <= w_cnt_next;
            r_addr  <= w_addr_next;
            r_inc_d <= w_inc_s;
            r_ena   <= (w_state_next == ST_ON);
            r_busy  <= (w_state_next == ST_PRE) || (w_state_next == ST_UPD) ||
                       (w_state_next == ST_POST);
        end
    end

    assign addr = r_addr;
    assign ena  = r_ena;
    assign busy = r_busy;
    assign wrap = w_wrap;

endmodule
